muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair and sits beside the ALU in the EX stage of the five-stage MIPS pipeline. EX issues MULT/MULTU/DIV/DIVU operands with a one-cycle start pulse. The unit computes over 33 cycles and asserts a stall request to the hazard unit while busy. MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write them through dedicated write ports.

## Interface
Parameters:
- `WIDTH`, 32, operand width; fixed at 32 for this pipeline.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle issue strobe from EX; sampled only in IDLE.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; feeds the stall logic.
- `done`  out  1  one-cycle pulse when `hi`/`lo` receive a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
States:
- IDLE.
- CALC: 32 iterations, tracked by a 5-bit counter.
- FIX.

IDLE behaviour:
- On `start`, latch `op`.
- For signed ops (MULT, DIV), latch |a| and |b| and record the result signs:
  - sign_q/prod = a[31]^b[31].
  - sign_r = a[31].
- For unsigned ops, latch the raw operands.
- Clear the accumulator and counter, then go to CALC.

CALC, multiply: radix-2 shift-add on a 64-bit {acc, multiplier}.
- If multiplier LSB = 1, acc += multiplicand, with a 33-bit carry.
- Shift the full 64-bit pair right by 1.

CALC, divide: restoring division on a 64-bit {rem, quot}.
- Shift left by 1.
- Trial-subtract the divisor from rem[63:32].
- If the result is non-negative, keep it and set quot LSB.

CALC exit: after counter reaches 31, go to FIX.

FIX:
- Apply sign correction:
  - Product: negate the 64-bit result if sign_prod.
  - Quotient: negate if sign_q.
  - Remainder: negate if sign_r.
- Write the result: product → {hi, lo}; quotient → `lo`; remainder → `hi`.
- Pulse `done`, then return to IDLE.

Divide by zero (b = 0, signed or unsigned):
- `lo` = 32'hFFFF_FFFF, `hi` = a (original dividend).
- Full latency is still taken.

Signed overflow, DIV 0x8000_0000 / 0xFFFF_FFFF:
- `lo` = 0x8000_0000, `hi` = 0, i.e. natural two's-complement wrap. No exception.

MTHI/MTLO:
- Honoured only in IDLE.
- In the same cycle as `start`, the write takes effect and the operation still launches; its result later overwrites the written value.
- Ignored while `busy`. The pipeline is stalled then, so this case does not occur in legal operation.

`start` while busy is ignored.

## Timing
Reset values: state IDLE, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0.

Cycle sequence:
- Edge E0: `start` sampled in IDLE.
- E0 through E32: `busy` is 1. This covers 32 CALC cycles plus the FIX cycle.
- E33 (FIX edge): `hi`/`lo` update.
- Cycle after E33: `done` is 1 for exactly one cycle and `busy` is 0.
- Latency: 33 cycles from start to result visible.
- Back-to-back: a new `start` may be asserted in the same cycle `done` is high and is accepted.

Hazard rule:
- The hazard unit stalls IF/ID/EX while `busy | (start & ~busy)`.
- MFHI/MFLO in ID must stall until `busy` = 0.
- Forwarding is not provided: `hi`/`lo` are valid the cycle `done` rises.

Reset in any state:
- Returns the unit to IDLE at the next edge and clears `hi`/`lo`.
- Any partial result is discarded and `done` is not pulsed.

## Structure
- Shared header `muldiv_defs.vh` holds the `op` encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`) and state encodings. The CU includes it to generate `op`.
- The control FSM and datapath stay in the single module.
- One sub-module, `negate64`: a conditional two's-complement negator (64-bit in, enable, 64-bit out). It is used for the product and, on 32-bit halves, for the quotient and remainder.
- Integration at the top level: `busy` feeds FU's stall inputs; `hi`/`lo` feed the EX result mux for MFHI/MFLO.

## Test plan
- MULTU a = 0xFFFF_FFFF, b = 0xFFFF_FFFF → hi = 0xFFFF_FFFE, lo = 0x0000_0001, done pulses in the cycle after E33.
- MULT a = −7 (0xFFFF_FFF9), b = 6 → hi = 0xFFFF_FFFF, lo = 0xFFFF_FFD6; busy is high for exactly 33 cycles.
- DIV a = −7, b = 2 → lo = 0xFFFF_FFFD (−3), hi = 0xFFFF_FFFF (−1); DIVU 100 / 7 → lo = 14, hi = 2.
- DIVU b = 0 with a = 0x1234_5678 → lo = 0xFFFF_FFFF, hi = 0x1234_5678; DIV 0x8000_0000 / −1 → lo = 0x8000_0000, hi = 0.
- MTLO wdata = 0xA5A5_A5A5 in IDLE → lo updates next edge. MTHI while busy → hi is unchanged. Start while busy → ignored, and the first result is intact.
- Reset asserted at CALC iteration 10 → next cycle busy = 0, hi = lo = 0, no done. A start immediately after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;

  localparam logic [4:0] LAST_ITER = 5'd31;

  // Magnitude of a two's-complement value when en is set, raw value otherwise.
  function automatic logic [31:0] abs_if(input logic [31:0] x, input logic en);
    return (en && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_negate64.sv
// Conditional 64-bit two's-complement negator used for sign correction of results.
module negate64 (
  input  logic [63:0] in_i,
  input  logic        en_i,
  output logic [63:0] out_o
);

  assign out_o = en_i ? (~in_i + 64'd1) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 32 CALC cycles plus one FIX cycle,
// busy_o holds the pipeline stalled for the whole operation.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic        is_div_q;
  logic        sign_ab_q;
  logic        sign_rem_q;
  logic        div0_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] opnd_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pair_q;
  logic [63:0] pair_d;

  logic [32:0] mul_sum;
  logic [64:0] mul_wide;
  logic [32:0] rem_sh;
  logic [33:0] div_diff;

  logic        start_signed;
  logic        start_div;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  logic [63:0] prod_fix;
  logic [63:0] quot_neg;
  logic [63:0] rem_neg;
  logic [64:0] unused_bits;

  // pair_q is {acc, multiplier} for multiply and {rem, quot} for divide.
  always_comb begin
    mul_sum  = {1'b0, pair_q[63:32]} + {1'b0, opnd_q};
    mul_wide = pair_q[0] ? {mul_sum, pair_q[31:0]} : {1'b0, pair_q};
    rem_sh   = {pair_q[63:32], pair_q[31]};
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    pair_d   = mul_wide[64:1];
    if (is_div_q) begin
      if (!div_diff[33]) begin
        pair_d = {div_diff[31:0], pair_q[30:0], 1'b1};
      end else begin
        pair_d = {rem_sh[31:0], pair_q[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    start_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
    start_div    = (op_i == MD_DIV) || (op_i == MD_DIVU);
    a_abs        = abs_if(a_i, start_signed);
    b_abs        = abs_if(b_i, start_signed);
  end

  negate64 u_neg_prod (
    .in_i  (pair_q),
    .en_i  (sign_ab_q),
    .out_o (prod_fix)
  );

  negate64 u_neg_quot (
    .in_i  ({32'd0, pair_q[31:0]}),
    .en_i  (sign_ab_q),
    .out_o (quot_neg)
  );

  // Remainder sits in the upper half so the negated value lands there too.
  negate64 u_neg_rem (
    .in_i  ({pair_q[63:32], 32'd0}),
    .en_i  (sign_rem_q),
    .out_o (rem_neg)
  );

  assign unused_bits = {quot_neg[63:32], rem_neg[31:0], div_diff[32]};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      is_div_q   <= 1'b0;
      sign_ab_q  <= 1'b0;
      sign_rem_q <= 1'b0;
      div0_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      opnd_q     <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pair_q     <= 64'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we_i) hi_q <= wdata_i;
          if (lo_we_i) lo_q <= wdata_i;
          if (start_i) begin
            is_div_q   <= start_div;
            sign_ab_q  <= start_signed & (a_i[31] ^ b_i[31]);
            sign_rem_q <= start_signed & a_i[31];
            div0_q     <= start_div & (b_i == 32'd0);
            opnd_q     <= start_div ? b_abs : a_abs;
            pair_q     <= {32'd0, start_div ? a_abs : b_abs};
            cnt_q      <= 5'd0;
            busy_q     <= 1'b1;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          pair_q <= pair_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_q <= rem_neg[63:32];
            lo_q <= div0_q ? 32'hFFFF_FFFF : quot_neg[31:0];
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result values, 33-cycle busy window and IDLE-only side effects.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NV = 10;
  vec_t vt[NV];

  muldiv_unit #(.WIDTH(32)) dut (
    .clock_i (clk),
    .reset_i (reset),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .wdata_i (wdata),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Caller must be at a negedge; start is raised immediately so back-to-back issue is possible.
  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      @(negedge clk);
      if (done) done_at = k;
      else if (busy) busy_cnt++;
    end
    chk({nm, "_done_cycle"}, done_at, 34);
    chk({nm, "_busy_cycles"}, busy_cnt, 33);
    chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
  endtask

  initial begin
    int done_at;
    int done_seen;

    vt[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vt[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vt[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vt[4] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vt[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vt[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vt[7] = '{2'b00, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[8] = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vt[9] = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // MTLO in IDLE lands on the next edge, HI untouched.
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1 lo_we = 1'b0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hA5A5_A5A5);
    chk("mtlo_hi", hi, 32'd0);

    // Vectors issue back-to-back: each new start coincides with the previous done.
    for (int i = 0; i < NV; i++) begin
      do_op($sformatf("v%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo);
    end

    // MTHI and a second start while busy are both ignored.
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1 begin hi_we = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("mthi_busy_hi", hi, vt[NV-1].hi);
    chk("mthi_busy_busy", {63'd0, busy}, 64'd1);
    done_at = 0;
    for (int k = 7; k <= 60 && done_at == 0; k++) begin
      @(negedge clk);
      if (done) done_at = k;
    end
    chk("busy_start_done_cycle", done_at, 34);
    chk("busy_start_hi", hi, 32'd0);
    chk("busy_start_lo", lo, 32'd15);

    // Reset mid-CALC discards the operation and clears HI/LO without a done pulse.
    @(negedge clk);
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst_no_done", done_seen, 0);

    do_op("post_rst", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
